// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encoding
// and the slice width.
package nibble_serial_subtractor_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_cla4_slice.sv
// Purely combinational 4-bit carry look-ahead adder. The subtractor reuses
// it by feeding an inverted subtrahend nibble.
module cla4_slice
  import nibble_serial_subtractor_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is a flat sum-of-products of g/p/cin, so no carry ripples.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[NIBBLE_W-1:0];
  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b computed one nibble per clock through
// a single CLA slice, with the borrow (as an inverted carry) chained between steps.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             borrow_q, ovf_q, zero_q;

  logic [NIBBLE_W-1:0] a_nib, b_nib, sum_nib;
  logic                cout;
  logic                accept, last_step;

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (state == CALC) && (cnt == LAST);

  assign a_nib = a_q[cnt*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[cnt*NIBBLE_W +: NIBBLE_W];

  cla4_slice u_slice (
    .x    (a_nib),
    .y    (~b_nib),
    .cin  (carry),
    .s    (sum_nib),
    .cout (cout)
  );

  // The final flags need the full result including the nibble written this cycle.
  always_comb begin
    diff_nxt = diff_q;
    diff_nxt[cnt*NIBBLE_W +: NIBBLE_W] = sum_nib;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: assigning a default before the case keeps unlisted paths from
  // inferring a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      carry    <= 1'b1;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      cnt   <= '0;
      carry <= 1'b1;
    end else if (state == CALC) begin
      diff_q <= diff_nxt;
      carry  <= cout;
      cnt    <= cnt + 1'b1;
      if (last_step) begin
        borrow_q <= ~cout;
        ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
        zero_q   <= (diff_nxt == '0);
      end
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle unsigned/two's-complement subtractor. Computes diff = a - b for WIDTH-bit operands, 4 bits per clock, through one 4-bit carry look-ahead slice with the borrow chained between nibbles.
- It is the inverse-operation counterpart of the team's 4-bit CLA adder. Ripple-free area is traded for latency.
- Sits behind a valid/ready producer, such as an ALU issue stage, and feeds a valid/ready consumer.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  1 when a < b unsigned
- ovf  output  1  signed overflow
- zero  output  1  diff == 0

Behaviour:
- Single clock clk; reset rst_n is synchronous, active-low. It is sampled only on the rising edge of clk.
- Reset state is IDLE:
  - in_ready=1
  - out_valid=0
  - diff=0, borrow=0, ovf=0, zero=0
  - internal nibble counter=0; carry register=1
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a and b into operand registers, set the carry register to 1 and the counter to 0, and go to CALC.
- CALC: in_ready=0, out_valid=0.
  - Each cycle, the slice computes a_nib + ~b_nib + carry, where the nibble is selected by the counter with the LSB nibble first.
  - The 4-bit result is written to the matching diff nibble. Carry-out goes to the carry register. The counter increments.
  - After the step with counter==NIB-1, go to DONE.
- DONE:
  - out_valid=1.
  - borrow = ~final carry.
  - ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured operands.
  - zero = (diff==0).
  - On out_ready, go to IDLE. out_valid falls and in_ready rises on the next edge.
- Latency: operands accepted at edge T0 give out_valid high after edge T0+NIB.
- Result registers diff/borrow/ovf/zero:
  - Stable throughout DONE while out_ready=0 (backpressure); there is no timeout.
  - Hold their last values in IDLE. out_valid alone qualifies them.
- Throughput: at most one operation per NIB+2 cycles. There is no overlap of accept and result.
- in_valid while not in IDLE is ignored. Operand inputs are don't-care outside the accept cycle.
- Reset asserted in any state, including mid-CALC: abort the operation and return to reset values on that edge. The partial result is discarded.
- WIDTH=4 degenerates to NIB=1: a single CALC cycle.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, CALC=2'd1, DONE=2'd2
  - NIBBLE_W=4
- One natural sub-module: cla4_slice, a purely combinational 4-bit carry look-ahead adder.
  - Inputs: x[3:0], y[3:0], cin.
  - Outputs: s[3:0], cout.
  - Generate/propagate logic: g=x&y, p=x^y, with look-ahead carry equations.
  - Instantiated once; the top inverts b_nib before the slice.

Test Plan (WIDTH=16, NIB=4, out_ready=1 unless stated):
1. a=0x0000, b=0x0000 -> out_valid exactly 4 cycles after accept; diff=0x0000, borrow=0, ovf=0, zero=1; in_ready=0 from accept until the cycle after the result handshake.
2. a=0x0003, b=0x0005 -> diff=0xFFFE, borrow=1, ovf=0, zero=0.
3. a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1. Also a=0x1000, b=0x0001 -> diff=0x0FFF, borrow=0, ovf=0, exercising borrow ripple through three nibbles.
4. a=0x1234, b=0x1234 with out_ready held 0 for 3 cycles after out_valid -> out_valid, diff=0x0000, and zero=1 stay constant; in_ready=0 throughout. Release out_ready -> out_valid=0 and in_ready=1 on the next edge.
5. Accept a=0xFFFF, b=0x0001, then drive rst_n=0 for one edge after 2 CALC cycles -> all outputs at reset values, state IDLE. A following op a=0x00F0, b=0x000F gives diff=0x00E1, borrow=0, 4-cycle latency.
6. in_valid pulsed with a=0x5555, b=0x1111 during CALC of a prior op a=0x0010, b=0x0001 -> the pulse is ignored; the result is diff=0x000F, and no second out_valid appears.
